// File: rtl/multicycle_main_ctrl_v2_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state codes,
// opcode values and the datapath select encodings driven by the FSM.
package multicycle_main_ctrl_v2_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_main_ctrl_v2_if.sv
// Controller <-> datapath bundle: opcode/memory-ready in, mux selects and
// enables out. master = controller side, slave = datapath side.
interface multicycle_main_ctrl_v2_if;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       Branch;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal, State
    );
endinterface

// File: rtl/multicycle_main_ctrl_v2.sv
// Multicycle MIPS main control FSM. Outputs are decoded from the registered
// state (plus memory-ready in FETCH and the opcode in IMMEX) so that they are
// valid in the same cycle as the state, including directly out of reset.
module multicycle_main_ctrl_v2
    import multicycle_main_ctrl_v2_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b0,
    parameter bit EN_MEM        = 1'b1,
    parameter bit EN_JUMP       = 1'b1,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_main_ctrl_v2_if.master   bus
);

    state_t     state_r;
    state_t     state_next_s;
    state_t     illegal_next_s;
    logic       rdy_s;

    logic       pc_write_s, branch_s, iord_s, mem_read_s, mem_write_s;
    logic       ir_write_s, reg_dst_s, memto_reg_s, reg_write_s, alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_op_s;
    logic [1:0] pc_src_s;
    logic       illegal_s;

    // Memory is treated as always ready when the handshake is disabled.
    assign rdy_s          = MEM_HANDSHAKE ? bus.MemReady : 1'b1;
    assign illegal_next_s = TRAP_ILLEGAL ? S_TRAP : S_FETCH;

    // State register; async reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection and Moore output decode; everything defaults to 0.
    always_comb begin
        state_next_s = S_FETCH;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        memto_reg_s  = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_B;
        alu_op_s     = ALU_ADD;
        pc_src_s     = PCSRC_ALU;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s   = 1'b1;
                ir_write_s   = rdy_s;
                pc_write_s   = rdy_s;
                alu_src_b_s  = SRCB_FOUR;
                state_next_s = rdy_s ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_s = SRCB_IMMSH2;
                case (bus.Opcode)
                    OP_RTYPE:                state_next_s = S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next_s = S_IMMEX;
                    OP_BEQ:                  state_next_s = S_BRANCH;
                    OP_LW, OP_SW:            state_next_s = EN_MEM ? S_MEMADR : illegal_next_s;
                    OP_J:                    state_next_s = EN_JUMP ? S_JUMP : illegal_next_s;
                    default:                 state_next_s = illegal_next_s;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                if (bus.Opcode == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else if (bus.Opcode == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord_s       = 1'b1;
                mem_read_s   = 1'b1;
                state_next_s = rdy_s ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memto_reg_s  = 1'b1;
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                iord_s       = 1'b1;
                mem_write_s  = 1'b1;
                state_next_s = rdy_s ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALU_FUNCT;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_s    = 1'b1;
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALU_SUB;
                branch_s     = 1'b1;
                pc_src_s     = PCSRC_ALUOUT;
                state_next_s = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_IMM;
                case (bus.Opcode)
                    OP_ORI:  alu_op_s = ALU_OR;
                    OP_ANDI: alu_op_s = ALU_AND;
                    default: alu_op_s = ALU_ADD;
                endcase
                state_next_s = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_src_s     = PCSRC_JUMP;
                state_next_s = S_FETCH;
            end
            S_TRAP: begin
                illegal_s    = 1'b1;
                state_next_s = S_TRAP;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    assign bus.PCWrite  = pc_write_s;
    assign bus.Branch   = branch_s;
    assign bus.IorD     = iord_s;
    assign bus.MemRead  = mem_read_s;
    assign bus.MemWrite = mem_write_s;
    assign bus.IRWrite  = ir_write_s;
    assign bus.RegDst   = reg_dst_s;
    assign bus.MemtoReg = memto_reg_s;
    assign bus.RegWrite = reg_write_s;
    assign bus.ALUSrcA  = alu_src_a_s;
    assign bus.ALUSrcB  = alu_src_b_s;
    assign bus.ALUOp    = alu_op_s;
    assign bus.PCSrc    = pc_src_s;
    assign bus.Illegal  = illegal_s;
    assign bus.State    = state_r;

endmodule

// File: tb/tb_multicycle_main_ctrl_v2.sv
// Scoreboard bench: every cycle's expected state and control vector is queued
// with the stimulus, then popped and compared one cycle at a time.
// dut0: handshake on, full decode, trap on. dut1: no handshake, no mem/jump,
// illegal opcodes act as NOPs.
module tb_multicycle_main_ctrl_v2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_main_ctrl_v2_if bus0();
    multicycle_main_ctrl_v2_if bus1();

    multicycle_main_ctrl_v2 #(.MEM_HANDSHAKE(1'b1), .EN_MEM(1'b1), .EN_JUMP(1'b1), .TRAP_ILLEGAL(1'b1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    multicycle_main_ctrl_v2 #(.MEM_HANDSHAKE(1'b0), .EN_MEM(1'b0), .EN_JUMP(1'b0), .TRAP_ILLEGAL(1'b0))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,Illegal}
    logic [17:0] ctrl0, ctrl1;
    assign ctrl0 = {bus0.PCWrite, bus0.Branch, bus0.IorD, bus0.MemRead, bus0.MemWrite, bus0.IRWrite,
                    bus0.RegDst, bus0.MemtoReg, bus0.RegWrite, bus0.ALUSrcA, bus0.ALUSrcB,
                    bus0.ALUOp, bus0.PCSrc, bus0.Illegal};
    assign ctrl1 = {bus1.PCWrite, bus1.Branch, bus1.IorD, bus1.MemRead, bus1.MemWrite, bus1.IRWrite,
                    bus1.RegDst, bus1.MemtoReg, bus1.RegWrite, bus1.ALUSrcA, bus1.ALUSrcB,
                    bus1.ALUOp, bus1.PCSrc, bus1.Illegal};

    typedef struct {
        int          dut;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctrl;
        string       tag;
    } step_t;

    step_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference control table, written from the state/output description.
    function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        logic pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ill;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
        pcw = 1'b0; br = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
        rdst = 1'b0; m2r = 1'b0; rw = 1'b0; asa = 1'b0; ill = 1'b0;
        asb = 2'b00; aop = 3'b000; pcs = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; irw = rdy; pcw = rdy; asb = 2'b01; end
            4'd1:  begin asb = 2'b11; end
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin iord = 1'b1; mrd = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin iord = 1'b1; mwr = 1'b1; end
            4'd6:  begin asa = 1'b1; aop = 3'b010; end
            4'd7:  begin rdst = 1'b1; rw = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 3'b001; br = 1'b1; pcs = 2'b01; end
            4'd9:  begin
                asa = 1'b1; asb = 2'b10;
                if (op == 6'h0D)      aop = 3'b011;
                else if (op == 6'h0C) aop = 3'b100;
                else                  aop = 3'b000;
            end
            4'd10: begin rw = 1'b1; end
            4'd11: begin pcw = 1'b1; pcs = 2'b10; end
            4'd12: begin ill = 1'b1; end
            default: begin end
        endcase
        return {pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Queue n cycles whose expected states are the hex nibbles of seq (MSB first).
    task automatic push_seq(input int dut, input string tag, input logic [5:0] op,
                            input logic mr, input logic rdy_m, input logic [63:0] seq, input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.dut  = dut;
            s.op   = op;
            s.mr   = mr;
            s.st   = seq[4*(n-1-i) +: 4];
            s.ctrl = exp_ctrl(s.st, op, rdy_m);
            s.tag  = $sformatf("%s[%0d]", tag, i);
            sb.push_back(s);
        end
    endtask

    // Drive each queued step, compare mid-cycle, then advance one clock.
    task automatic run_queue();
        step_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.dut == 0) begin
                bus0.Opcode = r.op; bus0.MemReady = r.mr;
            end else begin
                bus1.Opcode = r.op; bus1.MemReady = r.mr;
            end
            #2;
            if (r.dut == 0) begin
                check_eq({r.tag, " state"}, 32'(bus0.State), 32'(r.st));
                check_eq({r.tag, " ctrl"},  32'(ctrl0),      32'(r.ctrl));
            end else begin
                check_eq({r.tag, " state"}, 32'(bus1.State), 32'(r.st));
                check_eq({r.tag, " ctrl"},  32'(ctrl1),      32'(r.ctrl));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.Opcode = 6'h00; bus0.MemReady = 1'b1;
        bus1.Opcode = 6'h00; bus1.MemReady = 1'b0;
        @(negedge clk);
        check_eq("reset state0", 32'(bus0.State), 32'd0);
        check_eq("reset ctrl0",  32'(ctrl0), 32'(exp_ctrl(4'd0, 6'h00, 1'b1)));
        check_eq("reset state1", 32'(bus1.State), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // dut0: FETCH stall then R-type
        push_seq(0, "fstall", 6'h00, 1'b0, 1'b0, 64'h00, 2);
        push_seq(0, "rtype",  6'h00, 1'b1, 1'b1, 64'h0167, 4);
        push_seq(0, "ori",    6'h0D, 1'b1, 1'b1, 64'h019A, 4);
        push_seq(0, "andi",   6'h0C, 1'b1, 1'b1, 64'h019A, 4);
        push_seq(0, "addi",   6'h08, 1'b1, 1'b1, 64'h019A, 4);
        // LW with three stalled MEMRD cycles
        push_seq(0, "lw",      6'h23, 1'b1, 1'b1, 64'h012, 3);
        push_seq(0, "lwstall", 6'h23, 1'b0, 1'b0, 64'h333, 3);
        push_seq(0, "lwdone",  6'h23, 1'b1, 1'b1, 64'h34, 2);
        push_seq(0, "sw",      6'h2B, 1'b1, 1'b1, 64'h0125, 4);
        // SW with MemWrite held across a two-cycle stall
        push_seq(0, "sw2",      6'h2B, 1'b1, 1'b1, 64'h012, 3);
        push_seq(0, "sw2stall", 6'h2B, 1'b0, 1'b0, 64'h55, 2);
        push_seq(0, "sw2done",  6'h2B, 1'b1, 1'b1, 64'h5, 1);
        push_seq(0, "beq",  6'h04, 1'b1, 1'b1, 64'h018, 3);
        push_seq(0, "j",    6'h02, 1'b1, 1'b1, 64'h01B, 3);
        push_seq(0, "trap", 6'h3F, 1'b1, 1'b1, 64'h01CCCCCCCCCC, 12);
        run_queue();

        // Async reset out of TRAP
        rst_n = 1'b0;
        #1;
        check_eq("trap reset state", 32'(bus0.State), 32'd0);
        check_eq("trap reset ill",   32'(bus0.Illegal), 32'd0);
        check_eq("trap reset ctrl",  32'(ctrl0), 32'(exp_ctrl(4'd0, bus0.Opcode, bus0.MemReady)));
        @(negedge clk);
        rst_n = 1'b1;

        // dut1: MemReady ignored, illegal/LW/J decode straight back to FETCH
        push_seq(1, "nop",    6'h3F, 1'b0, 1'b1, 64'h01, 2);
        push_seq(1, "lwoff",  6'h23, 1'b0, 1'b1, 64'h01, 2);
        push_seq(1, "joff",   6'h02, 1'b0, 1'b1, 64'h01, 2);
        push_seq(1, "rtype1", 6'h00, 1'b0, 1'b1, 64'h0167, 4);
        push_seq(1, "beq1",   6'h04, 1'b0, 1'b1, 64'h018, 3);
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
